imem_loader: RTL

Writer-side companion to the core's instruction memory. It takes a byte stream from a host-side link (valid/ready), parses a length header, assembles little-endian 32-bit words, and issues single-cycle word writes into the instruction memory's write port. The core is held in reset while loading runs. A trailing checksum validates the image.

---
 rtl/imem_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads a program image from a byte stream into the instruction memory.
// The image format is a 16-bit little-endian word count, then count*4 data bytes
// that are packed into little-endian words, then one checksum byte. The checksum
// is the 8-bit wrapping sum of the data bytes.
// The core is held in reset from start until the image loads with a good checksum.
//
// Ports:
//   clk, rst_n             clock (rising edge) and async active-low reset
//   start                  load request pulse (honoured in IDLE/DONE/ERR)
//   in_valid/in_data       byte stream in; in_ready = busy
//   imem_we/waddr/wdata    one-cycle word write into instruction memory
//   core_rst_n             low hold on the core until DONE
//   busy, done, err        registered status decoded from state
module imem_loader #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned WIDX_W = $clog2(IMEM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [23:0]         sh_q, sh_d;
  logic [7:0]          csum_q, csum_d;
  logic [31:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                crst_q, crst_d;

  logic        accept;
  logic [15:0] len_full;

  assign accept   = in_valid & busy_q;
  assign len_full = {in_data, cnt_q[7:0]};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      csum_q  <= '0;
      addr_q  <= BASE_ADDR;
      we_q    <= 1'b0;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      crst_q  <= crst_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN0;
          cnt_d   = '0;
          widx_d  = '0;
          bidx_d  = '0;
          csum_d  = '0;
          addr_d  = BASE_ADDR;
        end
      end
      S_LEN0: begin
        if (accept) begin
          cnt_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          cnt_d = len_full;
          if (len_full == 16'd0)                        state_d = S_CSUM;
          else if ({16'd0, len_full} > 32'(IMEM_WORDS)) state_d = S_ERR;
          else                                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q + in_data;
          bidx_d = bidx_q + 2'd1;
          // Right-shifting keeps the earliest byte lowest once the word is full.
          sh_d   = {in_data, sh_q[23:8]};
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {in_data, sh_q};
            waddr_d = addr_q;
            addr_d  = addr_q + 32'd4;
            widx_d  = widx_q + 1'b1;
            if (32'(widx_q) + 32'd1 == 32'(cnt_q)) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q;
  // this keeps in_ready from accepting a stray byte on entry to DONE/ERR.
  always_comb begin
    busy_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
             (state_d == S_DATA) || (state_d == S_CSUM);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    crst_d = (state_d == S_DONE);
  end

  assign in_ready   = busy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign core_rst_n = crst_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

endmodule
